// File: rtl/intpol2_d4_out_fifo.sv
// Output FIFO behind the intpol2_D4 controlpath: a synchronous buffer with a registered
// read port, occupancy flags, an almost-full stall flag and sticky overflow/underflow flags.
module intpol2_d4_out_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  Empty,
  output logic                  Full,
  output logic                  Afull,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf,
  output logic                  udf
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH + 1)'(DEPTH - AFULL_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  // Flags come from the registered count only, never from wr_en/rd_en.
  assign Empty = (count == '0);
  assign Full  = (count == DEPTH_LVL);
  assign Afull = (count >= AFULL_LVL);

  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  assign do_wr = wr_en & (~Full | rd_en);
  assign do_rd = rd_en & ~Empty;

  always_ff @(posedge clk) begin
    if (rstn && !clear && do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      dout_valid <= do_rd;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && Full && !rd_en) begin
        ovf <= 1'b1;
      end
      if (rd_en && Empty) begin
        udf <= 1'b1;
      end
    end
  end

endmodule
